uart_rx_deserializer: RTL

- 8N1 UART receiver that turns the serial RX pin into bytes with a one-cycle ready strobe.
- Sits directly upstream of the PUF readout controller: drives its uart_rx_ready / uart_data_from_rx inputs, which carry the 's' (0x73) dump command from the host.
- Synchronises the asynchronous pin, rejects start-bit glitches, majority-votes each bit and flags framing errors.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx_deserializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Serial-receive bundle: pin in, byte/strobe/status out.
// The slave side is the deserializer; the master side is whoever drives the pin and consumes bytes.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       busy;

  modport master (
    output rxd,
    input  rx_data,
    input  rx_ready,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rxd,
    output rx_data,
    output rx_ready,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: two-flop synchroniser, start-glitch rejection, 3-sample majority
// per bit, framing-error strobe and break hold-off. Feeds the PUF readout command path.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave rx_if
);

  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW  = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
      $error("uart_rx_deserializer: CLKS_PER_BIT must be >= 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic          rxd_meta_q, rxd_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          samp0_q, samp0_d;
  logic          samp1_q, samp1_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_ready_q, rx_ready_d;
  logic          frame_err_q, frame_err_d;

  logic          maj;
  logic          cnt_last;
  logic          cnt_dec;

  // Synchroniser resets high so a reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rx_if.rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      samp0_q     <= 1'b1;
      samp1_q     <= 1'b1;
      rx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      samp0_q     <= samp0_d;
      samp1_q     <= samp1_d;
      rx_data_q   <= rx_data_d;
      rx_ready_q  <= rx_ready_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Third sample is the live synchronised value at the decision count.
  assign maj      = (samp0_q & samp1_q) | (samp0_q & rxd_s_q) | (samp1_q & rxd_s_q);
  assign cnt_last = (cnt_q == CNT_LAST);
  assign cnt_dec  = (cnt_q == CNT_DEC);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    samp0_d     = samp0_q;
    samp1_d     = samp1_q;
    rx_data_d   = rx_data_q;
    rx_ready_d  = 1'b0;
    frame_err_d = 1'b0;

    if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
      cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
      if (cnt_q == CNT_PRE) samp0_d = rxd_s_q;
      if (cnt_q == CNT_MID) samp1_d = rxd_s_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rxd_s_q) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_dec && maj) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_last) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (cnt_dec) shift_d = {maj, shift_q[7:1]};
        if (cnt_last) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end

      // Leave at the stop-bit centre so back-to-back frames get half a bit of slack.
      ST_STOP: begin
        if (cnt_dec) begin
          cnt_d = '0;
          if (maj) begin
            rx_data_d  = shift_q;
            rx_ready_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK_WAIT;
          end
        end
      end

      ST_BREAK_WAIT: begin
        if (rxd_s_q) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_ready  = rx_ready_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.busy      = (state_q != ST_IDLE);

endmodule
